// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - 3-bit opcode constants (OP_ADD .. OP_CMP)
//   - bit positions of the {N,Z,C,V} status flags
//   - FSM state encoding
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst   clock and synchronous active-high reset (aborts any operation)
//   start      load operands a/b and begin a WIDTH-step multiply
//   a, b       multiplicand / multiplier, sampled when start is high
//   done       high in the cycle whose rising edge performs the final step
//   product    2*WIDTH product as it will be after the current step; valid
//              as the final result while done is high
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;

  // Add the shifted multiplicand whenever the current multiplier LSB is set.
  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // Exposing the next accumulator lets the top capture the product on the
  // same edge that performs the last step.
  assign product = acc_next;
  assign done    = (count_reg == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (start) begin
      count_reg  <= CW'(WIDTH);
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
    end else if (count_reg != '0) begin
      count_reg  <= count_reg - CW'(1);
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      acc_reg    <= acc_next;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with valid/ready handshake and registered result/flags.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   alu_sel      request valid; accepted on an edge with alu_sel && alu_ready
//   alu_order    opcode (see alu_seq_pkg), sampled at accept
//   reg_1, reg_2 operands A and B, sampled at accept
//   alu_ready    high while idle
//   alu_out      result (low half for MUL; held for CMP)
//   alu_out_hi   MUL high half, 0 after other ops (held for CMP)
//   alu_valid    one-cycle pulse when outputs have been updated
//   alu_flags    {N,Z,C,V}
// Single-cycle ops complete on the accepting edge; MUL (when MUL_EN=1) runs
// in the shift-add sub-module for WIDTH further edges.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_sel,
  input  logic [2:0]       alu_order,
  input  logic [WIDTH-1:0] reg_1,
  input  logic [WIDTH-1:0] reg_2,
  output logic             alu_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             alu_valid,
  output logic [3:0]       alu_flags
);

  state_t             state_reg;
  logic [WIDTH-1:0]   out_reg;
  logic [WIDTH-1:0]   out_hi_reg;
  logic               valid_reg;
  logic [3:0]         flags_reg;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   mul_hi;
  logic [3:0]         mul_flags;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH-1:0]   res;
  logic               flag_c;
  logic               flag_v;
  logic [3:0]         res_flags;

  assign alu_ready  = (state_reg == ST_IDLE);
  assign alu_out    = out_reg;
  assign alu_out_hi = out_hi_reg;
  assign alu_valid  = valid_reg;
  assign alu_flags  = flags_reg;

  assign accept    = alu_sel && (state_reg == ST_IDLE);
  assign mul_start = accept && (alu_order == OP_MUL) && (MUL_EN != 0);

  // Single-cycle datapath. CMP shares the subtractor; MUL lands here only
  // when the multiplier is not built, giving result 0 with Z=1.
  assign sum_ext  = {1'b0, reg_1} + {1'b0, reg_2};
  assign diff_ext = {1'b0, reg_1} - {1'b0, reg_2};

  always_comb begin
    res    = '0;
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (alu_order)
      OP_ADD: begin
        res    = sum_ext[WIDTH-1:0];
        flag_c = sum_ext[WIDTH];
        flag_v = (reg_1[WIDTH-1] == reg_2[WIDTH-1]) &&
                 (sum_ext[WIDTH-1] != reg_1[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res    = diff_ext[WIDTH-1:0];
        // The extra top bit of the zero-extended difference is the borrow.
        flag_c = diff_ext[WIDTH];
        flag_v = (reg_1[WIDTH-1] != reg_2[WIDTH-1]) &&
                 (diff_ext[WIDTH-1] != reg_1[WIDTH-1]);
      end
      OP_AND: res = reg_1 & reg_2;
      OP_OR:  res = reg_1 | reg_2;
      OP_XOR: res = reg_1 ^ reg_2;
      OP_NOT: res = ~reg_1;
      default: res = '0;
    endcase
  end

  always_comb begin
    res_flags         = '0;
    res_flags[FLAG_N] = res[WIDTH-1];
    res_flags[FLAG_Z] = (res == '0);
    res_flags[FLAG_C] = flag_c;
    res_flags[FLAG_V] = flag_v;
  end

  // MUL flags: N from the high half, Z over the whole product, C/V flag a
  // product that does not fit in WIDTH bits.
  assign mul_hi = mul_product[2*WIDTH-1:WIDTH];

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_hi[WIDTH-1];
    mul_flags[FLAG_Z] = (mul_product == '0);
    mul_flags[FLAG_C] = (mul_hi != '0);
    mul_flags[FLAG_V] = (mul_hi != '0);
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_seq_mul #(
        .WIDTH(WIDTH)
      ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (reg_1),
        .b       (reg_2),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      out_reg    <= '0;
      out_hi_reg <= '0;
      valid_reg  <= 1'b0;
      flags_reg  <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (mul_start) begin
              state_reg <= ST_BUSY;
            end else begin
              valid_reg <= 1'b1;
              flags_reg <= res_flags;
              if (alu_order != OP_CMP) begin
                out_reg    <= res;
                out_hi_reg <= '0;
              end
            end
          end
        end
        ST_BUSY: begin
          // Requests are ignored here; only the multiplier finishing matters.
          if (mul_done) begin
            out_reg    <= mul_product[WIDTH-1:0];
            out_hi_reg <= mul_hi;
            flags_reg  <= mul_flags;
            valid_reg  <= 1'b1;
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         alu_sel;
  logic [2:0]   alu_order;
  logic [W-1:0] reg_1;
  logic [W-1:0] reg_2;
  logic         alu_ready;
  logic [W-1:0] alu_out;
  logic [W-1:0] alu_out_hi;
  logic         alu_valid;
  logic [3:0]   alu_flags;

  int total = 0;
  int bad   = 0;

  // Reference state: what the outputs should show after the latest op.
  logic [7:0] exp_out   = 8'h00;
  logic [7:0] exp_hi    = 8'h00;
  logic [3:0] exp_flags = 4'h0;
  int         exp_lat   = 0;

  alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_sel    (alu_sel),
    .alu_order  (alu_order),
    .reg_1      (reg_1),
    .reg_2      (reg_2),
    .alu_ready  (alu_ready),
    .alu_out    (alu_out),
    .alu_out_hi (alu_out_hi),
    .alu_valid  (alu_valid),
    .alu_flags  (alu_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Arithmetic model built from the opcode definitions with plain integers.
  task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, r, p;
    logic n, z, c, v;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; r = 0;
    exp_lat = 0;
    case (op)
      3'd0: begin r = (ua + ub) % 256; c = (ua + ub) > 255;
                  v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1, 3'd7: begin r = (ua - ub + 256) % 256; c = ua < ub;
                  v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 255 - ua;
      default: r = 0;
    endcase
    if (op == 3'd6) begin
      p = ua * ub;
      exp_out   = 8'(p % 256);
      exp_hi    = 8'(p / 256);
      exp_flags = {exp_hi >= 8'd128, p == 0, exp_hi != 8'd0, exp_hi != 8'd0};
      exp_lat   = W;
    end else begin
      n = r >= 128; z = (r == 0);
      exp_flags = {n, z, c, v};
      if (op != 3'd7) begin
        exp_out = 8'(r);
        exp_hi  = 8'h00;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".valid"}, 32'(alu_valid), 32'd1);
    chk({tag, ".out"},   32'(alu_out),   32'(exp_out));
    chk({tag, ".hi"},    32'(alu_out_hi), 32'(exp_hi));
    chk({tag, ".flags"}, 32'(alu_flags), 32'(exp_flags));
  endtask

  // Issue one op, wait (bounded) for its valid, check latency and outputs,
  // then check that valid drops while outputs hold. With interfere set, an
  // ADD request with different operands is driven during the busy window.
  task automatic issue(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input bit interfere);
    int lat, low_cnt, w;
    w = 0;
    @(negedge clk);
    while (!alu_ready && w < 50) begin @(negedge clk); w++; end
    alu_sel = 1'b1; alu_order = op; reg_1 = a; reg_2 = b;
    model(op, a, b);
    @(posedge clk); #1;
    alu_sel = 1'b0;
    lat = 0; low_cnt = 0;
    while (!alu_valid && lat < 20) begin
      if (!alu_ready) low_cnt++;
      if (interfere && lat >= 1 && lat <= 4) begin
        alu_sel = 1'b1; alu_order = 3'd0; reg_1 = 8'h11; reg_2 = 8'h22;
      end else begin
        alu_sel = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    alu_sel = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    if (exp_lat != 0) chk({tag, ".ready_low"}, 32'(low_cnt), 32'(exp_lat));
    check_outs(tag);
    @(posedge clk); #1;
    chk({tag, ".valid_drop"}, 32'(alu_valid), 32'd0);
    chk({tag, ".hold"}, 32'({alu_out_hi, alu_out}), 32'({exp_hi, exp_out}));
    $display("op %s: op=%0d a=%02h b=%02h out=%02h hi=%02h flags=%04b lat=%0d",
             tag, op, a, b, alu_out, alu_out_hi, alu_flags, lat);
  endtask

  initial begin
    rst = 1'b1; alu_sel = 1'b0; alu_order = 3'd0; reg_1 = '0; reg_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out",   32'(alu_out),    32'd0);
    chk("reset.hi",    32'(alu_out_hi), 32'd0);
    chk("reset.flags", 32'(alu_flags),  32'd0);
    chk("reset.valid", 32'(alu_valid),  32'd0);
    chk("reset.ready", 32'(alu_ready),  32'd1);
    $display("reset: out=%02h ready=%0b", alu_out, alu_ready);

    // rst wins over a simultaneous request.
    alu_sel = 1'b1; alu_order = 3'd0; reg_1 = 8'h01; reg_2 = 8'h02;
    @(posedge clk); #1;
    alu_sel = 1'b0; rst = 1'b0;
    chk("rst_sel.valid", 32'(alu_valid), 32'd0);
    chk("rst_sel.out",   32'(alu_out),   32'd0);
    $display("rst+sel: valid=%0b out=%02h", alu_valid, alu_out);

    issue("add_f0_0f", 3'd0, 8'hF0, 8'h0F, 1'b0);
    chk("add_f0_0f.flags_const", 32'(alu_flags), 32'b1000);

    // Back-to-back accepts: ADD 80+80 then SUB 00-01.
    @(negedge clk);
    alu_sel = 1'b1; alu_order = 3'd0; reg_1 = 8'h80; reg_2 = 8'h80;
    model(3'd0, 8'h80, 8'h80);
    @(posedge clk); #1;
    check_outs("b2b_add");
    chk("b2b_add.flags_const", 32'(alu_flags), 32'b0111);
    $display("b2b add: out=%02h flags=%04b", alu_out, alu_flags);
    alu_order = 3'd1; reg_1 = 8'h00; reg_2 = 8'h01;
    model(3'd1, 8'h00, 8'h01);
    @(posedge clk); #1;
    alu_sel = 1'b0;
    check_outs("b2b_sub");
    chk("b2b_sub.flags_const", 32'(alu_flags), 32'b1010);
    $display("b2b sub: out=%02h flags=%04b", alu_out, alu_flags);
    @(posedge clk); #1;
    chk("b2b.valid_drop", 32'(alu_valid), 32'd0);

    issue("xor", 3'd4, 8'hF0, 8'h0F, 1'b0);
    issue("cmp_eq", 3'd7, 8'h05, 8'h05, 1'b0);
    chk("cmp_eq.out_held", 32'(alu_out), 32'hFF);
    chk("cmp_eq.flags_const", 32'(alu_flags), 32'b0100);

    issue("mul_f0_0f", 3'd6, 8'hF0, 8'h0F, 1'b0);
    chk("mul_f0_0f.value", 32'({alu_out_hi, alu_out}), 32'h0E10);
    chk("mul_f0_0f.flags_const", 32'(alu_flags), 32'b0011);

    issue("mul_busy_sel", 3'd6, 8'hF0, 8'h0F, 1'b1);
    chk("mul_busy_sel.value", 32'({alu_out_hi, alu_out}), 32'h0E10);

    issue("mul_zero", 3'd6, 8'h00, 8'h9C, 1'b0);
    issue("mul_max", 3'd6, 8'hFF, 8'hFF, 1'b0);

    // Reset during the fourth busy cycle aborts the multiply.
    @(negedge clk);
    alu_sel = 1'b1; alu_order = 3'd6; reg_1 = 8'h37; reg_2 = 8'hA5;
    @(posedge clk); #1;
    alu_sel = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort.no_valid", 32'(alu_valid), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.valid", 32'(alu_valid),  32'd0);
    chk("abort.out",   32'(alu_out),    32'd0);
    chk("abort.hi",    32'(alu_out_hi), 32'd0);
    chk("abort.flags", 32'(alu_flags),  32'd0);
    chk("abort.ready", 32'(alu_ready),  32'd1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("abort.quiet", 32'(alu_valid), 32'd0);
    end
    $display("abort: out=%02h ready=%0b", alu_out, alu_ready);
    exp_out = 8'h00; exp_hi = 8'h00; exp_flags = 4'h0;
    issue("add_1_1", 3'd0, 8'h01, 8'h01, 1'b0);
    chk("add_1_1.value", 32'(alu_out), 32'h02);

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if (i % 10 == 3) b = a;
      issue($sformatf("rnd%0d", i), op, a, b, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
